cpu_trace_display: RTL and testbench

Debug monitor sitting on the output side of the pipelined CPU top level, consuming the `PC_out` / `instr_out` / `clkd_out` stream that the CPU produces. It records the last DEPTH (PC, instruction) pairs, one per rising edge of the divided CPU clock, into a circular history buffer. It scan-drives an 8-digit active-low seven-segment display with a switch-selected entry and field. Together with the switch inputs it forms the board-facing interface of the CPU.

---
 rtl/cpu_trace_pkg.sv | 10 +
 rtl/seg7_hex_decode.sv | 28 ++
 rtl/cpu_trace_display.sv | 81 ++++++++
 tb/tb_cpu_trace_display.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared display constants, field selects and switch bit positions
package cpu_trace_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  typedef enum logic {SEL_PC = 1'b0, SEL_INSTR = 1'b1} field_sel_e;
  localparam int SW_SEL    = 0;
  localparam int SW_OFS_LO = 1;
  localparam int SW_OFS_HI = 3;
  localparam int SW_FREEZE = 15;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit nibble to active-low g..a seven-segment pattern
module seg7_hex_decode (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // hex glyph lookup, segments active-low
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
  end
endmodule

// File: rtl/cpu_trace_display.sv
// cpu_trace_display: (PC, instr) history capture with scanned seven-segment readout
module cpu_trace_display
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_clk,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic [15:0] s,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [4:0]  cap_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [2:0]    sync_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, ofs, rd_idx;
  logic [4:0]    cap_count_q, cap_count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  logic [63:0]   hist_q [DEPTH];
  logic [63:0]   rd_word;
  logic [31:0]   word;
  logic [6:0]    hex;
  logic          strobe, cap_en, dash, wrap;
  logic          unused_s;
  assign unused_s  = ^s[14:4];
  assign strobe    = sync_q[1] & ~sync_q[2];
  assign cap_en    = strobe & ~s[SW_FREEZE];
  assign wrap      = presc_q == PW'(SCAN_DIV - 1);
  assign ofs       = AW'(s[SW_OFS_HI:SW_OFS_LO]);
  assign rd_idx    = wr_ptr_q - AW'(1) - ofs;
  assign rd_word   = hist_q[rd_idx];
  assign word      = field_sel_e'(s[SW_SEL]) == SEL_INSTR ? rd_word[31:0] : rd_word[63:32];
  assign dash      = {2'b00, s[SW_OFS_HI:SW_OFS_LO]} >= cap_count_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign cap_count = cap_count_q;
  seg7_hex_decode u_dec (
    .nib_i (word[{digit_q, 2'b00} +: 4]),
    .seg_o (hex)
  );
  // next-state for capture pointers, scan counters and registered display
  always_comb begin
    wr_ptr_d    = cap_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cap_count_d = (cap_en && cap_count_q != 5'(DEPTH)) ? cap_count_q + 5'd1 : cap_count_q;
    presc_d     = wrap ? '0 : presc_q + PW'(1);
    digit_d     = wrap ? digit_q + 3'd1 : digit_q;
    an_d        = ~(8'd1 << digit_q);
    seg_d       = {~(digit_q == 3'd0 && s[SW_FREEZE]), dash ? SEG_DASH[6:0] : hex};
  end
  // state registers; synchronizer resets high so a cpu_clk held high is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 3'b111;
      wr_ptr_q    <= '0;
      cap_count_q <= '0;
      presc_q     <= '0;
      digit_q     <= '0;
      an_q        <= SEG_BLANK;
      seg_q       <= SEG_BLANK;
    end else begin
      sync_q      <= {sync_q[1:0], cpu_clk};
      wr_ptr_q    <= wr_ptr_d;
      cap_count_q <= cap_count_d;
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end
  // history write port; contents need no reset
  always_ff @(posedge clk) begin
    if (cap_en) hist_q[wr_ptr_q] <= {pc_in, instr_in};
  end
endmodule

// File: tb/tb_cpu_trace_display.sv
// tb_cpu_trace_display: directed table-driven bench for the trace display
module tb_cpu_trace_display;
  logic        clk = 0, rst_n = 0, cpu_clk = 0;
  logic [31:0] pc_in = 0, instr_in = 0;
  logic [15:0] s = 0;
  logic [7:0]  an, seg;
  logic [4:0]  cap_count;
  int errors = 0, checks = 0;

  typedef struct {
    logic [15:0] sw;
    int          dig;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [22];

  cpu_trace_display #(.DEPTH(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_clk(cpu_clk), .pc_in(pc_in), .instr_in(instr_in),
    .s(s), .an(an), .seg(seg), .cap_count(cap_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    pc_in = pc; instr_in = ins; cpu_clk = 1;
    repeat (3) @(negedge clk);
    cpu_clk = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      logic [7:0] tgt;
      bit found;
      found = 0;
      s = tbl[i].sw;
      tgt = ~(8'd1 << tbl[i].dig);
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge clk);
        if (an === tgt) found = 1;
      end
      if (!found) chk($sformatf("vec%0d_digit_timeout", i), {24'h0, an}, {24'h0, tgt});
      else chk($sformatf("vec%0d_seg", i), {24'h0, seg}, {24'h0, tbl[i].exp});
    end
  endtask

  initial begin
    tbl[0]  = '{16'h0000, 0, 8'h99};
    tbl[1]  = '{16'h0000, 1, 8'hC0};
    tbl[2]  = '{16'h0000, 7, 8'hC0};
    tbl[3]  = '{16'h0001, 0, 8'h88};
    tbl[4]  = '{16'h0001, 7, 8'hA4};
    tbl[5]  = '{16'h0002, 0, 8'hBF};
    tbl[6]  = '{16'h000E, 3, 8'hBF};
    tbl[7]  = '{16'h0000, 0, 8'h99};
    tbl[8]  = '{16'h0000, 1, 8'hA4};
    tbl[9]  = '{16'h0000, 2, 8'hC0};
    tbl[10] = '{16'h000E, 0, 8'h80};
    tbl[11] = '{16'h000E, 1, 8'hC0};
    tbl[12] = '{16'h000F, 0, 8'hA4};
    tbl[13] = '{16'h000F, 1, 8'h86};
    tbl[14] = '{16'h000F, 2, 8'hA1};
    tbl[15] = '{16'h000F, 4, 8'h83};
    tbl[16] = '{16'h000F, 5, 8'h88};
    tbl[17] = '{16'h000F, 7, 8'h80};
    tbl[18] = '{16'h0003, 0, 8'h80};
    tbl[19] = '{16'h0004, 0, 8'hC6};
    tbl[20] = '{16'h0004, 1, 8'hF9};
    tbl[21] = '{16'h0006, 0, 8'h80};

    repeat (3) @(negedge clk);
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    chk("rst_cap", {27'h0, cap_count}, 32'h0);
    rst_n = 1;
    @(negedge clk);
    chk("first_seg_dash", {24'h0, seg}, 32'hBF);
    chk("first_cap", {27'h0, cap_count}, 32'h0);
    chk("scan_an0", {24'h0, an}, 32'hFE);
    for (int n = 2; n <= 36; n++) begin
      logic [7:0] e;
      @(negedge clk);
      e = ~(8'd1 << (((n - 1) / 4) % 8));
      chk($sformatf("scan_an%0d", n - 1), {24'h0, an}, {24'h0, e});
    end

    pulse(32'h00000004, 32'h2008000A);
    chk("single_cap", {27'h0, cap_count}, 32'd1);
    run_vecs(0, 6);

    s = 0;
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rerst_cap", {27'h0, cap_count}, 32'h0);
    for (int i = 0; i < 10; i++) pulse(32'(4 * i), 32'h89ABCDE0 + 32'(i));
    chk("sat_cap", {27'h0, cap_count}, 32'd8);
    run_vecs(7, 21);

    s = 16'h8000;
    for (int i = 0; i < 3; i++) pulse(32'hDEAD0000 + 32'(i), 32'h0);
    chk("frz_cap", {27'h0, cap_count}, 32'd8);
    tbl[0] = '{16'h8000, 0, 8'h19};
    tbl[1] = '{16'h8000, 1, 8'hA4};
    run_vecs(0, 1);
    s = 0;
    pulse(32'h00000040, 32'h0);
    chk("unfrz_cap", {27'h0, cap_count}, 32'd8);
    tbl[0] = '{16'h0000, 0, 8'hC0};
    tbl[1] = '{16'h0000, 1, 8'h99};
    tbl[2] = '{16'h0002, 0, 8'h99};
    tbl[3] = '{16'h0002, 1, 8'hA4};
    run_vecs(0, 3);

    s = 0;
    @(negedge clk); cpu_clk = 1; pc_in = 32'h00000100;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_an", {24'h0, an}, 32'hFF);
    chk("async_rst_cap", {27'h0, cap_count}, 32'h0);
    repeat (2) @(negedge clk); rst_n = 1;
    repeat (10) @(negedge clk);
    chk("hi_thru_rst_cap", {27'h0, cap_count}, 32'h0);
    cpu_clk = 0;
    repeat (3) @(negedge clk);
    cpu_clk = 1;
    repeat (2) @(negedge clk);
    chk("lat_before", {27'h0, cap_count}, 32'h0);
    @(negedge clk);
    chk("lat_after", {27'h0, cap_count}, 32'd1);
    cpu_clk = 0;
    tbl[0] = '{16'h0000, 2, 8'hF9};
    tbl[1] = '{16'h0000, 0, 8'hC0};
    run_vecs(0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
